// File: rtl/timer_a_pkg.sv
// Shared definitions for timer_a: register offsets, TACTL encodings,
// bit positions and TACTL pack/unpack helpers.
package timer_a_pkg;

  localparam int unsigned TACTL_OFF   = 'h00;
  localparam int unsigned TACCTL0_OFF = 'h02;
  localparam int unsigned TAR_OFF     = 'h10;
  localparam int unsigned TACCR0_OFF  = 'h12;

  typedef enum logic [1:0] {
    MC_STOP = 2'b00,
    MC_UP   = 2'b01,
    MC_CONT = 2'b10,
    MC_UPDN = 2'b11
  } mc_e;

  localparam logic [1:0] TASSEL_ACLK  = 2'b01;
  localparam logic [1:0] TASSEL_SMCLK = 2'b10;

  localparam int TASSEL_LSB = 8;
  localparam int ID_LSB     = 6;
  localparam int MC_LSB     = 4;
  localparam int TACLR_BIT  = 2;
  localparam int TAIE_BIT   = 1;
  localparam int TAIFG_BIT  = 0;
  localparam int CCIE_BIT   = 4;
  localparam int CCIFG_BIT  = 0;

  typedef struct packed {
    logic [1:0] tassel;
    logic [1:0] id;
    mc_e        mc;
    logic       taie;
    logic       taifg;
  } tactl_t;

  // TACLR and bit 3 are not stored and always read back as 0.
  function automatic logic [15:0] tactl_word(tactl_t c);
    return {6'b0, c.tassel, c.id, c.mc, 2'b00, c.taie, c.taifg};
  endfunction

  function automatic tactl_t tactl_load(logic [15:0] w, logic hw_set);
    tactl_t c;
    c.tassel = w[TASSEL_LSB+:2];
    c.id     = w[ID_LSB+:2];
    c.mc     = mc_e'(w[MC_LSB+:2]);
    c.taie   = w[TAIE_BIT];
    c.taifg  = w[TAIFG_BIT] | hw_set;
    return c;
  endfunction

endpackage

// File: rtl/timer_a_if.sv
// Peripheral bus bundle for timer_a: register access, CCR0 ack, irqs.
// master = bus side, slave = timer side.
interface timer_a_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [15:0]       wdata;
  logic [15:0]       rdata;
  logic              ccr0_ack;
  logic              irq_ccr0;
  logic              irq_ta;

  modport master (
    output addr, we, wdata, ccr0_ack,
    input  rdata, irq_ccr0, irq_ta
  );

  modport slave (
    input  addr, we, wdata, ccr0_ack,
    output rdata, irq_ccr0, irq_ta
  );
endinterface

// File: rtl/timer_a_tickgen.sv
// Count-tick generator: ACLK rising-edge detect, source mux, divider.
// Ports: MCLK, reset, ACLK, tassel, id, run, clr -> count_tick.
module timer_a_tickgen
  import timer_a_pkg::*;
(
  input  logic       MCLK,
  input  logic       reset,
  input  logic       ACLK,
  input  logic [1:0] tassel,
  input  logic [1:0] id,
  input  logic       run,
  input  logic       clr,
  output logic       count_tick
);

  logic       aclk_q;
  logic [2:0] div;
  logic [2:0] lim;
  logic       src_tick;
  logic       step;

  always_comb begin
    src_tick = 1'b0;
    unique case (1'b1)
      (tassel == TASSEL_ACLK):  src_tick = ACLK & ~aclk_q;
      (tassel == TASSEL_SMCLK): src_tick = 1'b1;
      default:                  src_tick = 1'b0;
    endcase
  end

  // id=3 gives 3'b000-1 = 7, i.e. divide by 8.
  assign lim        = (3'b001 << id) - 3'd1;
  assign step       = run & src_tick;
  assign count_tick = step & (div == lim);

  // An ID change lands at the next wrap: the counter is never
  // reloaded, it just runs on until it meets the new limit.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      aclk_q <= 1'b0;
      div    <= '0;
    end else begin
      aclk_q <= ACLK;
      if (clr)
        div <= '0;
      else if (step)
        div <= (div == lim) ? 3'd0 : div + 3'd1;
    end
  end

endmodule

// File: rtl/timer_a.sv
// Simplified Timer_A: 16-bit TAR, compare-only CCR0, TAIFG/CCIFG irqs.
// Ports: MCLK, reset, ACLK, bus (timer_a_if.slave).
module timer_a
  import timer_a_pkg::*;
#(
  parameter int          ADDR_W  = 5,
  parameter logic [15:0] TAR_RST = 16'h0000
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       ACLK,
  timer_a_if.slave   bus
);

  localparam logic [ADDR_W-1:0] A_CTL  = ADDR_W'(TACTL_OFF);
  localparam logic [ADDR_W-1:0] A_CCTL = ADDR_W'(TACCTL0_OFF);
  localparam logic [ADDR_W-1:0] A_TAR  = ADDR_W'(TAR_OFF);
  localparam logic [ADDR_W-1:0] A_CCR  = ADDR_W'(TACCR0_OFF);

  tactl_t      ctl;
  logic        ccie;
  logic        ccifg;
  logic [15:0] tar;
  logic [15:0] ccr0;
  logic        down;

  logic        wr_ctl, wr_cctl, wr_tar, wr_ccr;
  logic        clr, count_tick, cnt;
  logic        hold, set_cc, set_ta, down_nx;
  logic [15:0] inc, dec, tar_nx;
  logic [15:0] rd;

  assign wr_ctl  = bus.we & (bus.addr == A_CTL);
  assign wr_cctl = bus.we & (bus.addr == A_CCTL);
  assign wr_tar  = bus.we & (bus.addr == A_TAR);
  assign wr_ccr  = bus.we & (bus.addr == A_CCR);
  assign clr     = wr_ctl & bus.wdata[TACLR_BIT];

  timer_a_tickgen u_tickgen (
    .MCLK       (MCLK),
    .reset      (reset),
    .ACLK       (ACLK),
    .tassel     (ctl.tassel),
    .id         (ctl.id),
    .run        (ctl.mc != MC_STOP),
    .clr        (clr),
    .count_tick (count_tick)
  );

  // A TAR load or TACLR owns TAR this cycle: the tick is dropped
  // along with the flags it would have raised.
  assign cnt  = count_tick & ~wr_tar & ~clr;
  assign inc  = tar + 16'd1;
  assign dec  = tar - 16'd1;
  assign hold = (ccr0 == '0) & (tar == '0) &
                ((ctl.mc == MC_UP) | (ctl.mc == MC_UPDN));

  always_comb begin
    tar_nx  = tar;
    down_nx = down;
    set_cc  = 1'b0;
    set_ta  = 1'b0;
    if (cnt && !hold) begin
      unique case (ctl.mc)
        MC_UP: begin
          if (tar == ccr0) begin
            tar_nx = '0;
            set_ta = 1'b1;
          end else begin
            tar_nx = inc;
            set_ta = &tar;
            set_cc = (inc == ccr0);
          end
        end
        MC_CONT: begin
          tar_nx = inc;
          set_ta = &tar;
          set_cc = (inc == ccr0);
        end
        MC_UPDN: begin
          if (!down) begin
            tar_nx = inc;
            set_ta = &tar;
            if (inc == ccr0) begin
              set_cc  = 1'b1;
              down_nx = 1'b1;
            end
          end else if (tar == '0) begin
            down_nx = 1'b0;
          end else begin
            tar_nx = dec;
            if (dec == '0) begin
              set_ta  = 1'b1;
              down_nx = 1'b0;
            end
          end
        end
        MC_STOP: ;
      endcase
    end
  end

  // Hardware flag sets are ORed in last so they beat a same-cycle
  // software clear or ccr0_ack.
  always_ff @(posedge MCLK) begin
    if (reset) begin
      ctl   <= '0;
      ccie  <= 1'b0;
      ccifg <= 1'b0;
      tar   <= TAR_RST;
      ccr0  <= '0;
      down  <= 1'b0;
    end else begin
      tar  <= wr_tar ? bus.wdata : (clr ? TAR_RST : tar_nx);
      down <= clr ? 1'b0 : down_nx;
      if (wr_ctl)
        ctl <= tactl_load(bus.wdata, set_ta);
      else
        ctl.taifg <= ctl.taifg | set_ta;
      if (wr_ccr)
        ccr0 <= bus.wdata;
      if (wr_cctl) begin
        ccie  <= bus.wdata[CCIE_BIT];
        ccifg <= bus.wdata[CCIFG_BIT] | set_cc;
      end else begin
        ccifg <= set_cc | (ccifg & ~bus.ccr0_ack);
      end
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      (bus.addr == A_CTL):  rd = tactl_word(ctl);
      (bus.addr == A_CCTL): rd = {11'b0, ccie, 3'b0, ccifg};
      (bus.addr == A_TAR):  rd = tar;
      (bus.addr == A_CCR):  rd = ccr0;
      default:              rd = '0;
    endcase
  end

  assign bus.rdata    = rd;
  assign bus.irq_ccr0 = ccie & ccifg;
  assign bus.irq_ta   = ctl.taie & ctl.taifg;

endmodule

// File: tb/tb_timer_a.sv
// Self-checking bench for timer_a: register vectors, directed
// multi-cycle sequences, and random traffic against a reference model.
module tb_timer_a;
  import timer_a_pkg::*;

  localparam logic [4:0] A_CTL  = 5'h00;
  localparam logic [4:0] A_CCTL = 5'h02;
  localparam logic [4:0] A_TAR  = 5'h10;
  localparam logic [4:0] A_CCR  = 5'h12;

  logic MCLK  = 1'b0;
  logic reset = 1'b1;
  logic ACLK  = 1'b0;
  int   errors = 0;
  int   checks = 0;

  timer_a_if #(.ADDR_W(5)) bus ();

  timer_a #(.ADDR_W(5), .TAR_RST(16'h0000)) dut (
    .MCLK  (MCLK),
    .reset (reset),
    .ACLK  (ACLK),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic [4:0]  wa;
    logic        we;
    logic [15:0] wd;
    logic [4:0]  ra;
    logic [15:0] exp;
    logic        cc;
    logic        ta;
  } vec_t;

  vec_t vt [14];

  // reference model state
  int m_tar, m_ccr0, m_tassel, m_id, m_mc, m_div;
  bit m_taie, m_taifg, m_ccie, m_ccifg, m_down, m_aclk_prev;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    bus.addr  = a;
    bus.we    = 1'b1;
    bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a,
                        input logic [15:0] exp);
    bus.addr = a;
    #1;
    chk(nm, bus.rdata, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic model_reset();
    m_tar = 0; m_ccr0 = 0; m_tassel = 0; m_id = 0; m_mc = 0;
    m_div = 0; m_taie = 0; m_taifg = 0; m_ccie = 0; m_ccifg = 0;
    m_down = 0; m_aclk_prev = 0;
  endtask

  task automatic model_step(input logic [4:0] a, input logic w,
                            input logic [15:0] d, input logic ack,
                            input logic aclk);
    bit src, tk, hc, ht, sup;
    int t, c;
    t = m_tar; c = m_ccr0; hc = 0; ht = 0; tk = 0;
    src = (m_tassel == 1 && aclk && !m_aclk_prev) || (m_tassel == 2);
    if (m_mc != 0 && src) begin
      m_div = m_div + 1;
      if (m_div == (1 << m_id)) begin
        tk = 1;
        m_div = 0;
      end
    end
    sup = w && (a == A_TAR || (a == A_CTL && d[2]));
    if (tk && !sup) begin
      if (m_mc == 2) begin
        t = (t + 1) % 65536; ht = (t == 0); hc = (t == c);
      end else if (c == 0 && t == 0) begin
      end else if (m_mc == 1) begin
        if (t == c) begin
          t = 0; ht = 1;
        end else begin
          t = (t + 1) % 65536; ht = (t == 0); hc = (t == c);
        end
      end else if (!m_down) begin
        t = (t + 1) % 65536; ht = (t == 0);
        if (t == c) begin hc = 1; m_down = 1; end
      end else if (t > 0) begin
        t = t - 1;
        if (t == 0) begin ht = 1; m_down = 0; end
      end else begin
        m_down = 0;
      end
    end
    m_aclk_prev = aclk;
    if (w && a == A_CTL) begin
      m_tassel = int'(d[9:8]); m_id = int'(d[7:6]);
      m_mc = int'(d[5:4]); m_taie = d[1]; m_taifg = d[0] | ht;
      if (d[2]) begin t = 0; m_div = 0; m_down = 0; end
    end else begin
      m_taifg = m_taifg | ht;
    end
    if (w && a == A_TAR) t = int'(d);
    if (w && a == A_CCR) c = int'(d);
    if (w && a == A_CCTL) begin
      m_ccie = d[4]; m_ccifg = d[0] | hc;
    end else if (ack) begin
      m_ccifg = hc;
    end else begin
      m_ccifg = m_ccifg | hc;
    end
    m_tar = t; m_ccr0 = c;
  endtask

  function automatic logic [15:0] m_rd(input logic [4:0] a);
    case (a)
      A_CTL:  return 16'(m_tassel * 256 + m_id * 64 + m_mc * 16 +
                         int'(m_taie) * 2 + int'(m_taifg));
      A_CCTL: return 16'(int'(m_ccie) * 16 + int'(m_ccifg));
      A_TAR:  return 16'(m_tar);
      A_CCR:  return 16'(m_ccr0);
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    logic [15:0] exp_tar [6];
    logic [4:0]  ra [5];
    int bad;

    vt[0]  = '{A_CTL,  1'b1, 16'h0000, A_CTL,  16'h0000, 1'b0, 1'b0};
    vt[1]  = '{A_CTL,  1'b1, 16'hFFCB, A_CTL,  16'h03C3, 1'b0, 1'b1};
    vt[2]  = '{A_CCTL, 1'b1, 16'hFFFF, A_CCTL, 16'h0011, 1'b1, 1'b1};
    vt[3]  = '{A_TAR,  1'b1, 16'h1234, A_TAR,  16'h1234, 1'b1, 1'b1};
    vt[4]  = '{A_CCR,  1'b1, 16'hABCD, A_CCR,  16'hABCD, 1'b1, 1'b1};
    vt[5]  = '{5'h04,  1'b0, 16'hFFFF, 5'h04,  16'h0000, 1'b1, 1'b1};
    vt[6]  = '{5'h06,  1'b1, 16'hFFFF, 5'h1E,  16'h0000, 1'b1, 1'b1};
    vt[7]  = '{A_CCTL, 1'b1, 16'h0001, A_CCTL, 16'h0001, 1'b0, 1'b1};
    vt[8]  = '{A_CTL,  1'b1, 16'h0001, A_CTL,  16'h0001, 1'b0, 1'b0};
    vt[9]  = '{A_CTL,  1'b1, 16'h0004, A_TAR,  16'h0000, 1'b0, 1'b0};
    vt[10] = '{A_CCTL, 1'b1, 16'h0010, A_CCTL, 16'h0010, 1'b0, 1'b0};
    vt[11] = '{A_CTL,  1'b1, 16'h000B, A_CTL,  16'h0003, 1'b0, 1'b1};
    vt[12] = '{A_TAR,  1'b1, 16'hFFFF, A_TAR,  16'hFFFF, 1'b0, 1'b1};
    vt[13] = '{A_CTL,  1'b1, 16'h0004, A_CTL,  16'h0000, 1'b0, 1'b0};
    exp_tar = '{16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2};
    ra = '{A_CTL, A_CCTL, A_TAR, A_CCR, 5'h04};

    bus.addr = '0; bus.we = 1'b0; bus.wdata = '0; bus.ccr0_ack = 1'b0;
    do_reset();

    // reset state
    rd_chk("rst_ctl", A_CTL, 16'h0);
    rd_chk("rst_cctl", A_CCTL, 16'h0);
    rd_chk("rst_tar", A_TAR, 16'h0);
    rd_chk("rst_ccr", A_CCR, 16'h0);
    chk("rst_irq", 16'({bus.irq_ccr0, bus.irq_ta}), 16'h0);

    // register vectors, timer stopped
    for (int i = 0; i < 14; i++) begin
      bus.addr = vt[i].wa; bus.we = vt[i].we; bus.wdata = vt[i].wd;
      tick();
      bus.we = 1'b0;
      rd_chk($sformatf("vec%0d_rd", i), vt[i].ra, vt[i].exp);
      chk($sformatf("vec%0d_cc", i), 16'(bus.irq_ccr0), 16'(vt[i].cc));
      chk($sformatf("vec%0d_ta", i), 16'(bus.irq_ta), 16'(vt[i].ta));
    end

    // up mode, SMCLK /1, CCR0=4
    do_reset();
    wr(A_CCTL, 16'h0010);
    wr(A_CCR, 16'd4);
    wr(A_CTL, 16'h0210);
    bus.addr = A_TAR;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("up_tar%0d", k), bus.rdata, 16'(k % 5));
      chk($sformatf("up_cc%0d", k), 16'(bus.irq_ccr0), 16'(k >= 4));
      tick();
    end
    rd_chk("up_taifg", A_CTL, 16'h0211);

    // continuous, /8, wrap from FFFE
    wr(A_CTL, 16'h0004);
    wr(A_TAR, 16'hFFFE);
    wr(A_CTL, 16'h02E2);
    bus.addr = A_TAR;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("cont_tar%0d", i), bus.rdata,
          (i < 8) ? 16'hFFFE : ((i < 16) ? 16'hFFFF : 16'h0000));
      chk($sformatf("cont_ta%0d", i), 16'(bus.irq_ta), 16'(i == 16));
    end

    // up/down from ACLK rising edges, CCR0=2
    wr(A_CCTL, 16'h0010);
    wr(A_CCR, 16'd2);
    wr(A_CTL, 16'h0136);
    bus.addr = A_TAR;
    for (int k = 0; k < 6; k++) begin
      ACLK = 1'b1;
      repeat (15) tick();
      chk($sformatf("ud_rise%0d", k), bus.rdata, exp_tar[k]);
      chk($sformatf("ud_cc%0d", k), 16'(bus.irq_ccr0), 16'(k >= 1));
      chk($sformatf("ud_ta%0d", k), 16'(bus.irq_ta), 16'(k >= 3));
      ACLK = 1'b0;
      repeat (15) tick();
      chk($sformatf("ud_fall%0d", k), bus.rdata, exp_tar[k]);
    end

    // ack clears CCIFG; ack on a compare hit loses
    bus.ccr0_ack = 1'b1;
    tick();
    bus.ccr0_ack = 1'b0;
    chk("ack_clr", 16'(bus.irq_ccr0), 16'h0);
    wr(A_CCR, 16'd3);
    wr(A_CTL, 16'h0214);
    bus.addr = A_TAR;
    tick();
    tick();
    chk("ackhit_pre", bus.rdata, 16'd2);
    bus.ccr0_ack = 1'b1;
    tick();
    bus.ccr0_ack = 1'b0;
    chk("ackhit_tar", bus.rdata, 16'd3);
    chk("ackhit_cc", 16'(bus.irq_ccr0), 16'h1);

    // TACLR mid-count restarts TAR and divider
    wr(A_CTL, 16'h02A4);
    repeat (13) tick();
    wr(A_CTL, 16'h02A4);
    rd_chk("clr_tar", A_TAR, 16'h0);
    rd_chk("clr_ctl", A_CTL, 16'h02A0);
    bus.addr = A_TAR;
    repeat (3) tick();
    chk("clr_div3", bus.rdata, 16'h0);
    tick();
    chk("clr_div4", bus.rdata, 16'h1);

    // TAR write beats a same-cycle tick
    wr(A_CTL, 16'h0224);
    repeat (3) tick();
    wr(A_TAR, 16'h5555);
    rd_chk("tarwr_win", A_TAR, 16'h5555);
    tick();
    chk("tarwr_next", bus.rdata, 16'h5556);

    // up mode with CCR0=0 holds at 0
    wr(A_CTL, 16'h0004);
    wr(A_CCTL, 16'h0010);
    wr(A_CCR, 16'h0);
    wr(A_CTL, 16'h0216);
    bus.addr = A_TAR;
    bad = 0;
    repeat (100) begin
      tick();
      if (bus.rdata != 16'h0 || bus.irq_ccr0 || bus.irq_ta) bad++;
    end
    chk("hold0", 16'(bad), 16'h0);
    rd_chk("hold0_ctl", A_CTL, 16'h0212);

    // reset mid-count
    wr(A_CTL, 16'h0226);
    wr(A_CCTL, 16'h0011);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_irq", 16'({bus.irq_ccr0, bus.irq_ta}), 16'h0);
    rd_chk("mrst_ctl", A_CTL, 16'h0);
    rd_chk("mrst_cctl", A_CCTL, 16'h0);
    rd_chk("mrst_tar", A_TAR, 16'h0);
    rd_chk("mrst_ccr", A_CCR, 16'h0);
    wr(A_CTL, 16'h0220);
    rd_chk("mrst_from0", A_TAR, 16'h0);
    tick();
    chk("mrst_first", bus.rdata, 16'h1);

    // random traffic against the reference model
    ACLK = 1'b0;
    do_reset();
    model_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [4:0]  a;
      logic [15:0] d;
      logic        w, ack;
      r = int'($urandom_range(0, 99));
      a = ra[$urandom_range(0, 4)];
      w = 1'b0;
      d = 16'($urandom);
      if (r < 3) begin
        w = 1'b1; a = A_CTL;
        d = {6'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)), 1'b0, 1'b1,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0)};
      end else if (r < 6) begin
        w = 1'b1; a = A_TAR;
        d = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15))
                                        : 16'hFFF0 | 16'($urandom_range(0, 15));
      end else if (r < 10) begin
        w = 1'b1; a = A_CCR;
        d = 16'($urandom_range(0, 12));
      end else if (r < 12) begin
        w = 1'b1; a = A_CCTL;
        d = {11'b0, 1'($urandom_range(0, 1)), 3'b0,
             1'($urandom_range(0, 7) == 0)};
      end
      ack = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) ACLK = ~ACLK;
      bus.addr = a; bus.we = w; bus.wdata = d; bus.ccr0_ack = ack;
      @(posedge MCLK);
      model_step(a, w, d, ack, ACLK);
      #1;
      chk($sformatf("rnd%0d_rd@%h", n, a), bus.rdata, m_rd(a));
      chk($sformatf("rnd%0d_irq", n), 16'({bus.irq_ccr0, bus.irq_ta}),
          16'({m_ccie & m_ccifg, m_taie & m_taifg}));
    end
    bus.we = 1'b0;
    bus.ccr0_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
